regfile_wb_scheduler: RTL and testbench

Write-port scheduler and scoreboard for the 32x32 register file (single write port, two read ports).
- Arbitrates round-robin between two writeback requesters: req0 = ALU pipeline, req1 = load unit.
- Drives the register file's Regwrite/writereg/Datawrite from registered outputs.
- Tracks a pending bit per architectural register, so issue logic can stall on RAW (rs1_busy/rs2_busy) and WAW (issue_ready) hazards.
- Sits between the issue stage, the execution/load units and the register file.

---
 rtl/regfile_wb_scheduler.sv | 122 ++++++++++++
 tb/tb_regfile_wb_scheduler.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_scheduler.sv
// Writeback scheduler and pending-register scoreboard for a 32x32 register
// file with a single write port. Two writeback sources (ALU = req0, load
// unit = req1) share the port through a round-robin arbiter; the accepted
// write is registered and presented to the register file one cycle later.
// A pending bit per register lets issue logic stall on RAW and WAW hazards.
//
// Handshake: a request transfers at the rising edge where valid & ready are
// both high. Ready is combinational and depends only on the two valids and
// the round-robin state. A requester holding valid without ready must keep
// its rd and data stable until it is accepted.
module regfile_wb_scheduler #(
    parameter int N       = 32,
    parameter bit RR_INIT = 1'b0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         issue_valid,
    input  logic [4:0]   issue_rd,
    output logic         issue_ready,
    input  logic [4:0]   rs1,
    input  logic [4:0]   rs2,
    output logic         rs1_busy,
    output logic         rs2_busy,
    input  logic         req0_valid,
    input  logic [4:0]   req0_rd,
    input  logic [N-1:0] req0_data,
    output logic         req0_ready,
    input  logic         req1_valid,
    input  logic [4:0]   req1_rd,
    input  logic [N-1:0] req1_data,
    output logic         req1_ready,
    output logic         Regwrite,
    output logic [4:0]   writereg,
    output logic [N-1:0] Datawrite,
    output logic         wb_err
);

    logic [31:0]  pending_q, pending_d;
    logic         rr_last_q, rr_last_d;
    logic         regwrite_q, regwrite_d;
    logic [4:0]   writereg_q, writereg_d;
    logic [N-1:0] datawrite_q, datawrite_d;
    logic         wb_err_q, wb_err_d;

    logic         grant0, grant1, accept;
    logic [4:0]   acc_rd;
    logic [N-1:0] acc_data;
    logic [31:0]  set_mask, clr_mask;

    // Round-robin grant: a lone requester always wins, on contention the one
    // that did not win last time is served.
    always_comb begin
        grant0    = req0_valid && (!req1_valid || rr_last_q);
        grant1    = req1_valid && (!req0_valid || !rr_last_q);
        accept    = grant0 || grant1;
        acc_rd    = grant1 ? req1_rd : req0_rd;
        acc_data  = grant1 ? req1_data : req0_data;
        rr_last_d = rr_last_q;
        if (grant1) begin
            rr_last_d = 1'b1;
        end else if (grant0) begin
            rr_last_d = 1'b0;
        end
    end

    // Output register: accepted write appears one cycle later; x0 writes are
    // consumed but never raise the write enable.
    always_comb begin
        regwrite_d  = accept && (acc_rd != 5'd0);
        writereg_d  = writereg_q;
        datawrite_d = datawrite_q;
        if (accept) begin
            writereg_d  = acc_rd;
            datawrite_d = acc_data;
        end
    end

    // Scoreboard update: set on issue, clear on the edge the register file
    // captures the data (clear wins on a collision); flag writes to idle regs.
    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (issue_valid && issue_ready && (issue_rd != 5'd0)) begin
            set_mask[issue_rd] = 1'b1;
        end
        if (regwrite_q) begin
            clr_mask[writereg_q] = 1'b1;
        end
        pending_d = (pending_q | set_mask) & ~clr_mask;
        wb_err_d  = wb_err_q || (regwrite_q && !pending_q[writereg_q]);
    end

    // State registers; reset also discards any write held for the next cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q   <= '0;
            rr_last_q   <= ~RR_INIT;
            regwrite_q  <= 1'b0;
            writereg_q  <= '0;
            datawrite_q <= '0;
            wb_err_q    <= 1'b0;
        end else begin
            pending_q   <= pending_d;
            rr_last_q   <= rr_last_d;
            regwrite_q  <= regwrite_d;
            writereg_q  <= writereg_d;
            datawrite_q <= datawrite_d;
            wb_err_q    <= wb_err_d;
        end
    end

    assign issue_ready = !pending_q[issue_rd] || (issue_rd == 5'd0);
    assign rs1_busy    = (rs1 != 5'd0) && pending_q[rs1];
    assign rs2_busy    = (rs2 != 5'd0) && pending_q[rs2];
    assign req0_ready  = grant0;
    assign req1_ready  = grant1;
    assign Regwrite    = regwrite_q;
    assign writereg    = writereg_q;
    assign Datawrite   = datawrite_q;
    assign wb_err      = wb_err_q;

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Directed bench for regfile_wb_scheduler: reset state, RAW/WAW scoreboard,
// round-robin arbitration, x0 handling, sticky wb_err and async reset.
`timescale 1ns/1ps
module tb_regfile_wb_scheduler;

    localparam int N = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         issue_valid;
    logic [4:0]   issue_rd;
    logic         issue_ready;
    logic [4:0]   rs1, rs2;
    logic         rs1_busy, rs2_busy;
    logic         req0_valid, req1_valid;
    logic [4:0]   req0_rd, req1_rd;
    logic [N-1:0] req0_data, req1_data;
    logic         req0_ready, req1_ready;
    logic         Regwrite;
    logic [4:0]   writereg;
    logic [N-1:0] Datawrite;
    logic         wb_err;

    int n_checks = 0;
    int n_errors = 0;
    logic [4+N:0] exp_q[$];
    logic [4+N:0] dropped;
    logic [31:0]  pend_vec;
    logic [N-1:0] d0, d1;

    regfile_wb_scheduler #(.N(N), .RR_INIT(1'b0)) dut (
        .clk(clk), .rst_n(rst_n),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
        .rs1(rs1), .rs2(rs2), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .req0_valid(req0_valid), .req0_rd(req0_rd), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_rd(req1_rd), .req1_data(req1_data), .req1_ready(req1_ready),
        .Regwrite(Regwrite), .writereg(writereg), .Datawrite(Datawrite), .wb_err(wb_err)
    );

    // Clock
    always #50 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every register-file write must match the oldest expected one.
    always @(negedge clk) begin
        if (rst_n && Regwrite) begin
            if (exp_q.size() == 0) begin
                check("wb_unexpected", {63'd0, Regwrite}, 64'd0);
            end else begin
                check("wb_order", {27'd0, writereg, Datawrite}, {27'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic idle_inputs();
        issue_valid = 1'b0; issue_rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0;
        req0_valid = 1'b0; req0_rd = 5'd0; req0_data = '0;
        req1_valid = 1'b0; req1_rd = 5'd0; req1_data = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Reads the whole pending vector through the rs2 busy port.
    task automatic read_pending(output logic [31:0] v);
        v = '0;
        for (int i = 0; i < 32; i++) begin
            rs2 = 5'(i);
            #1;
            v[i] = rs2_busy;
        end
        rs2 = 5'd0;
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        issue_rd = 5'd5;
        #1;
        check("rst_regwrite", {63'd0, Regwrite}, 64'd0);
        check("rst_writereg", {59'd0, writereg}, 64'd0);
        check("rst_datawrite", {32'd0, Datawrite}, 64'd0);
        check("rst_wb_err", {63'd0, wb_err}, 64'd0);
        check("rst_issue_ready", {63'd0, issue_ready}, 64'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // RAW/WAW on x5, then writeback clears it
        @(negedge clk);
        issue_valid = 1'b1; issue_rd = 5'd5; #1;
        check("t1_issue_ready", {63'd0, issue_ready}, 64'd1);
        @(negedge clk);
        issue_valid = 1'b0; rs1 = 5'd5; #1;
        check("t1_rs1_busy", {63'd0, rs1_busy}, 64'd1);
        check("t1_waw_stall", {63'd0, issue_ready}, 64'd0);
        req0_valid = 1'b1; req0_rd = 5'd5; req0_data = 32'hDEADBEEF; #1;
        check("t1_req0_ready", {63'd0, req0_ready}, 64'd1);
        check("t1_req1_ready", {63'd0, req1_ready}, 64'd0);
        exp_q.push_back({5'd5, 32'hDEADBEEF});
        @(negedge clk);
        req0_valid = 1'b0; #1;
        check("t1_regwrite", {63'd0, Regwrite}, 64'd1);
        check("t1_writereg", {59'd0, writereg}, 64'd5);
        check("t1_datawrite", {32'd0, Datawrite}, 64'hDEADBEEF);
        check("t1_busy_during_wb", {63'd0, rs1_busy}, 64'd1);
        @(negedge clk);
        #1;
        check("t1_busy_cleared", {63'd0, rs1_busy}, 64'd0);
        check("t1_regwrite_off", {63'd0, Regwrite}, 64'd0);
        check("t1_writereg_hold", {59'd0, writereg}, 64'd5);
        check("t1_wb_err", {63'd0, wb_err}, 64'd0);

        // Round-robin between ALU (x3) and load (x7)
        do_reset();
        issue_valid = 1'b1; issue_rd = 5'd3;
        @(negedge clk);
        issue_rd = 5'd7;
        @(negedge clk);
        issue_valid = 1'b0;
        read_pending(pend_vec);
        check("t2_pending", {32'd0, pend_vec}, 64'h88);
        d0 = 32'hAAAA0000; d1 = 32'hBBBB0000;
        for (int c = 0; c < 4; c++) begin
            req0_valid = 1'b1; req0_rd = 5'd3; req0_data = d0;
            req1_valid = 1'b1; req1_rd = 5'd7; req1_data = d1;
            #1;
            check($sformatf("t2_req0_ready_%0d", c), {63'd0, req0_ready}, {63'd0, (c % 2 == 0)});
            check($sformatf("t2_req1_ready_%0d", c), {63'd0, req1_ready}, {63'd0, (c % 2 == 1)});
            if (c % 2 == 0) begin
                exp_q.push_back({5'd3, d0});
            end else begin
                exp_q.push_back({5'd7, d1});
            end
            @(negedge clk);
            if (c % 2 == 0) d0 = d0 + 1; else d1 = d1 + 1;
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clk);
        #1;
        check("t2_all_written", {32'd0, exp_q.size()}, 64'd0);
        check("t2_wb_err_rewrite", {63'd0, wb_err}, 64'd1);
        read_pending(pend_vec);
        check("t2_pending_clear", {32'd0, pend_vec}, 64'd0);

        // Load writeback to x0 is consumed silently
        do_reset();
        req1_valid = 1'b1; req1_rd = 5'd0; req1_data = 32'h12345678; #1;
        check("t3_req1_ready", {63'd0, req1_ready}, 64'd1);
        check("t3_req0_ready", {63'd0, req0_ready}, 64'd0);
        @(negedge clk);
        req1_valid = 1'b0; #1;
        check("t3_no_regwrite", {63'd0, Regwrite}, 64'd0);
        check("t3_wb_err", {63'd0, wb_err}, 64'd0);
        read_pending(pend_vec);
        check("t3_pending", {32'd0, pend_vec}, 64'd0);

        // Issue to x0 never marks anything pending
        @(negedge clk);
        issue_valid = 1'b1; issue_rd = 5'd0; #1;
        check("t4_issue_ready", {63'd0, issue_ready}, 64'd1);
        @(negedge clk);
        issue_valid = 1'b0; rs1 = 5'd0; #1;
        check("t4_rs1_busy", {63'd0, rs1_busy}, 64'd0);
        read_pending(pend_vec);
        check("t4_pending", {32'd0, pend_vec}, 64'd0);

        // Write to non-pending x9 raises sticky wb_err
        req0_valid = 1'b1; req0_rd = 5'd9; req0_data = 32'h00000099; #1;
        check("t5_req0_ready", {63'd0, req0_ready}, 64'd1);
        exp_q.push_back({5'd9, 32'h00000099});
        @(negedge clk);
        req0_valid = 1'b0; #1;
        check("t5_regwrite", {63'd0, Regwrite}, 64'd1);
        check("t5_writereg", {59'd0, writereg}, 64'd9);
        check("t5_wb_err_before", {63'd0, wb_err}, 64'd0);
        @(negedge clk);
        #1;
        check("t5_wb_err_set", {63'd0, wb_err}, 64'd1);
        repeat (3) @(negedge clk);
        #1;
        check("t5_wb_err_sticky", {63'd0, wb_err}, 64'd1);

        // Async reset drops the write held for the next cycle
        issue_valid = 1'b1; issue_rd = 5'd4; #1;
        check("t6_issue_ready", {63'd0, issue_ready}, 64'd1);
        @(negedge clk);
        issue_valid = 1'b0;
        req0_valid = 1'b1; req0_rd = 5'd4; req0_data = 32'h00000044; #1;
        check("t6_req0_ready", {63'd0, req0_ready}, 64'd1);
        exp_q.push_back({5'd4, 32'h00000044});
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        check("t6_regwrite_pre", {63'd0, Regwrite}, 64'd1);
        rst_n = 1'b0; rs1 = 5'd4; #1;
        check("t6_regwrite_reset", {63'd0, Regwrite}, 64'd0);
        check("t6_wb_err_reset", {63'd0, wb_err}, 64'd0);
        check("t6_rs1_busy_reset", {63'd0, rs1_busy}, 64'd0);
        dropped = exp_q.pop_front();
        read_pending(pend_vec);
        check("t6_pending_reset", {32'd0, pend_vec}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("final_queue_empty", {32'd0, exp_q.size()}, 64'd0);
        check("final_regwrite", {63'd0, Regwrite}, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
